fetch_stage: RTL

Parametrised instruction-fetch stage for the pipelined core: owns the program counter, drives the synchronous instruction memory, and buffers fetched instructions with their PCs in a small queue feeding decode. It generalises the fixed PC-plus-IF/ID-register front end. It adds decode back-pressure (stall), branch/jump redirect with flush of in-flight and queued fetches, and configurable width, queue depth and PC step.

---
 rtl/fetch_stage.sv | 103 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues synchronous imem reads and
// buffers returned {inst, pc} pairs in a small circular queue for decode.
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 26,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_en,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic [ADDR_W-1:0]          imem_addr,
  output logic                       imem_rd,
  input  logic [INST_W-1:0]          imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INST_W-1:0]          out_inst,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = CW + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pend_pc;
  logic              pending;
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  logic          pop;
  logic          push;
  logic          issue;
  logic [SW-1:0] credit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit check counts the in-flight fetch so the queue can never overflow.
  always_comb begin
    pop    = out_valid & out_ready;
    push   = pending & ~redirect_en;
    credit = SW'(count) + SW'(pending) - SW'(pop);
    issue  = ~rst & ~redirect_en & (credit < SW'(DEPTH));
  end

  assign imem_rd   = issue;
  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign out_inst  = inst_q[rd_ptr];
  assign out_pc    = pc_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      pend_pc  <= '0;
      pending  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (redirect_en) begin
      // Redirect wins: drop the in-flight response and every queued entry.
      fetch_pc <= redirect_pc;
      pending  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      pending <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        pend_pc  <= fetch_pc;
      end
      if (push) begin
        inst_q[wr_ptr] <= imem_rdata;
        pc_q[wr_ptr]   <= pend_pc;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == CW'(DEPTH))));

endmodule
